// File: rtl/down_timer8_pkg.sv
// Shared definitions for the 8-bit down-counter/timer: controller state
// encoding and the default counter width.
package down_timer8_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/down_timer8_subone.sv
// Combinational WIDTH-bit decrement (modulo 2^WIDTH); the controller keeps it
// from ever being used at zero.
module down_timer8_subone
   import down_timer8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] out_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   assign out_o = in_i - ONE;

endmodule

// File: rtl/down_timer8.sv
// Programmable down-counter/timer: load, start/stop, optional auto-reload and a
// registered one-cycle terminal-count pulse.
module down_timer8
   import down_timer8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             auto_rl_i,
   output logic [WIDTH-1:0] count_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             tc_o
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] count_dec;

   down_timer8_subone #(.WIDTH(WIDTH)) u_subone (
      .in_i  (count_q),
      .out_o (count_dec)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         count_q  <= ZERO;
         reload_q <= ZERO;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   // Command priority: load, then stop, then start / free-running count.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load_i) begin
         count_d  = load_val_i;
         reload_d = load_val_i;
         state_d  = IDLE;
      end else if (stop_i) begin
         if (state_q == RUN) begin
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (count_q != ZERO) begin
                     state_d = RUN;
                  end else begin
                     state_d = DONE;
                     tc_d    = 1'b1;
                  end
               end
            end
            RUN: begin
               if (count_q > ONE) begin
                  count_d = count_dec;
               end else if (count_q == ONE && auto_rl_i && reload_q != ZERO) begin
                  count_d = reload_q;
                  tc_d    = 1'b1;
               end else begin
                  count_d = ZERO;
                  state_d = DONE;
                  tc_d    = (count_q == ONE);
               end
            end
            DONE: begin
               count_d = ZERO;
               if (start_i) begin
                  if (reload_q != ZERO) begin
                     count_d = reload_q;
                     state_d = RUN;
                  end else begin
                     tc_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q == RUN);
   assign done_o  = (state_q == DONE);
   assign tc_o    = tc_q;

endmodule

// File: tb/tb_down_timer8.sv
// Scoreboard bench for down_timer8: a driver updates a behavioural timer model
// and queues the expected outputs; a monitor compares them after each event.
module tb_down_timer8;

   localparam int W = 8;

   logic         clk_i = 1'b0;
   logic         reset_ni;
   logic         load_i;
   logic [W-1:0] load_val_i;
   logic         start_i;
   logic         stop_i;
   logic         auto_rl_i;
   logic [W-1:0] count_o;
   logic         busy_o;
   logic         done_o;
   logic         tc_o;

   down_timer8 #(.WIDTH(W)) dut (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .auto_rl_i  (auto_rl_i),
      .count_o    (count_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .tc_o       (tc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int    cnt;
      bit    busy;
      bit    done;
      bit    tc;
      string tag;
   } exp_t;

   exp_t  sb_q[$];
   int    total = 0;
   int    bad   = 0;
   bit    mon_on = 1'b0;
   string tag = "reset";

   // Behavioural model: remaining count, reload value and whether the timer
   // is counting or has expired.
   int m_cnt, m_rl;
   bit m_running, m_finished, m_tc;

   function automatic void model_clear();
      m_cnt = 0; m_rl = 0; m_running = 0; m_finished = 0; m_tc = 0;
   endfunction

   function automatic void model_step(bit ld, int val, bit st, bit sp, bit ar);
      m_tc = 0;
      if (ld) begin
         m_cnt = val; m_rl = val; m_running = 0; m_finished = 0;
      end else if (sp) begin
         m_running = 0;
      end else if (m_running) begin
         if (m_cnt > 1) m_cnt = m_cnt - 1;
         else if (ar && m_rl > 0) begin m_cnt = m_rl; m_tc = 1; end
         else begin m_cnt = 0; m_running = 0; m_finished = 1; m_tc = 1; end
      end else if (st) begin
         if (m_finished) begin
            if (m_rl > 0) begin m_cnt = m_rl; m_running = 1; m_finished = 0; end
            else m_tc = 1;
         end else if (m_cnt > 0) m_running = 1;
         else begin m_finished = 1; m_tc = 1; end
      end
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.cnt = m_cnt; e.busy = m_running; e.done = m_finished; e.tc = m_tc; e.tag = tag;
      sb_q.push_back(e);
   endfunction

   task automatic cyc(bit ld, int val, bit st, bit sp, bit ar);
      load_i = ld; load_val_i = W'(val); start_i = st; stop_i = sp; auto_rl_i = ar;
      @(posedge clk_i);
      model_step(ld, val, st, sp, ar);
      push_exp();
      @(negedge clk_i);
   endtask

   task automatic idle(int n, bit ar);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ar);
   endtask

   task automatic reset_pulse();
      load_i = 0; start_i = 0; stop_i = 0; auto_rl_i = 0;
      model_clear();
      push_exp();
      reset_ni = 1'b0;
      @(posedge clk_i);
      push_exp();
      @(negedge clk_i);
      reset_ni = 1'b1;
   endtask

   task automatic chk(string what, int act, int req, string t);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s %s: got %0d want %0d at %0t", t, what, act, req, $time);
      end
   endtask

   // Monitor: one expectation per clock edge or reset assertion.
   initial begin
      wait (mon_on);
      forever begin
         @(posedge clk_i or negedge reset_ni);
         #1;
         if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL queue: no expectation for output at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("count", int'(count_o), e.cnt, e.tag);
            chk("busy", int'(busy_o), int'(e.busy), e.tag);
            chk("done", int'(done_o), int'(e.done), e.tag);
            chk("tc", int'(tc_o), int'(e.tc), e.tag);
         end
      end
   end

   initial begin
      reset_ni = 1'b0;
      load_i = 0; load_val_i = '0; start_i = 0; stop_i = 0; auto_rl_i = 0;
      model_clear();
      @(negedge clk_i);
      mon_on = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_i);
         push_exp();
         @(negedge clk_i);
      end
      reset_ni = 1'b1;
      idle(3, 0);

      tag = "start_at_zero";
      cyc(0, 0, 1, 0, 0);
      idle(2, 0);

      tag = "one_shot";
      cyc(1, 5, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(7, 0);

      tag = "auto_reload";
      cyc(1, 3, 0, 0, 1);
      cyc(0, 0, 1, 0, 1);
      idle(13, 1);

      tag = "auto_reload_one";
      cyc(1, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 1);
      idle(4, 1);
      cyc(0, 0, 0, 0, 0);
      idle(2, 0);

      tag = "pause_resume";
      cyc(1, 10, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(4, 0);
      cyc(0, 0, 0, 1, 0);
      idle(5, 0);
      cyc(0, 0, 1, 0, 0);
      idle(8, 0);

      tag = "priority";
      cyc(1, 9, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(2, 0);
      cyc(1, 7, 1, 1, 0);
      cyc(0, 0, 1, 0, 0);
      idle(2, 0);
      cyc(0, 0, 1, 1, 0);
      idle(2, 0);

      tag = "load_at_tc";
      cyc(1, 2, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(1, 0);
      cyc(1, 5, 0, 0, 0);
      idle(2, 0);

      tag = "done_restart";
      cyc(1, 2, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(3, 0);
      cyc(0, 0, 1, 0, 0);
      idle(3, 0);

      tag = "async_reset";
      cyc(1, 8, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(4, 0);
      #2;
      reset_pulse();
      idle(2, 0);

      tag = "random";
      for (int i = 0; i < 800; i++) begin
         bit ld, st, sp, ar;
         int v;
         if ($urandom_range(199) == 0) begin
            #2;
            reset_pulse();
         end
         ld = ($urandom_range(15) == 0);
         st = ($urandom_range(3) == 0);
         sp = ($urandom_range(11) == 0);
         ar = ($urandom_range(2) != 0);
         v  = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(6));
         cyc(ld, v, st, sp, ar);
      end

      idle(2, 0);
      mon_on = 1'b0;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
